// File: rtl/regfile_wport_arb_pkg.sv
// Shared types for the register-file writeback arbiter: queue entry, request
// bundle and the default queue depth.
package regfile_wport_arb_pkg;

  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] dat;
  } wb_entry_t;

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic [31:0] dat;
  } wb_req_t;

  function automatic wb_entry_t mk_entry(input wb_req_t req);
    wb_entry_t e;
    e.rd  = req.rd;
    e.dat = req.dat;
    return e;
  endfunction

endpackage

// File: rtl/regfile_wport_arb_if.sv
// Writeback bundle: two request channels, the register-file write port,
// decode read indices with the hazard flag, and queue occupancy.
interface regfile_wport_arb_if #(parameter int DEPTH = 4) ();

  logic                       alu_vld;
  logic [4:0]                 alu_rd;
  logic [31:0]                alu_dat;
  logic                       alu_rdy;
  logic                       mem_vld;
  logic [4:0]                 mem_rd;
  logic [31:0]                mem_dat;
  logic                       mem_rdy;
  logic                       wr_en;
  logic [4:0]                 wr_addr;
  logic [31:0]                wr_dat;
  logic [4:0]                 rs1_ind;
  logic [4:0]                 rs2_ind;
  logic                       hazard;
  logic [$clog2(DEPTH):0]     cnt;

  modport slave (
    input  alu_vld, alu_rd, alu_dat, mem_vld, mem_rd, mem_dat, rs1_ind, rs2_ind,
    output alu_rdy, mem_rdy, wr_en, wr_addr, wr_dat, hazard, cnt
  );

  modport master (
    output alu_vld, alu_rd, alu_dat, mem_vld, mem_rd, mem_dat, rs1_ind, rs2_ind,
    input  alu_rdy, mem_rdy, wr_en, wr_addr, wr_dat, hazard, cnt
  );

endinterface

// File: rtl/regfile_wport_arb_wb_fifo.sv
// In-order pending-write queue with up to two pushes (a before b) and one pop
// per cycle; exposes per-slot rd and validity for the hazard compare.
module wb_fifo
  import regfile_wport_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_a,
  input  wb_entry_t                     data_a,
  input  logic                          push_b,
  input  wb_entry_t                     data_b,
  input  logic                          pop,
  output wb_entry_t                     head,
  output logic [$clog2(DEPTH):0]        cnt,
  output logic [DEPTH-1:0]              vld_vec,
  output logic [DEPTH-1:0][4:0]         rd_vec
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;
  wb_entry_t     mem_r [DEPTH];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(push_a) + AW'(push_b);
      rd_ptr_r <= rd_ptr_r + AW'(pop);
      cnt_r    <= cnt_r + (AW+1)'(push_a) + (AW+1)'(push_b) - (AW+1)'(pop);
    end
  end

  // Entry storage; validity comes from the pointers, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_a) mem_r[wr_ptr_r] <= data_a;
    if (push_b) mem_r[wr_ptr_r + AW'(1)] <= data_b;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [AW-1:0] off_s;
    assign off_s      = AW'(i) - rd_ptr_r;
    assign vld_vec[i] = ({1'b0, off_s} < cnt_r);
    assign rd_vec[i]  = mem_r[i].rd;
  end

  assign head = mem_r[rd_ptr_r];
  assign cnt  = cnt_r;

endmodule

// File: rtl/regfile_wport_arb.sv
// Register-file write-port arbiter: merges ALU and load writebacks into one
// queue, drains one write per cycle and flags read-after-write hazards.
module regfile_wport_arb
  import regfile_wport_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wport_arb_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t                alu_req_s;
  wb_req_t                mem_req_s;
  wb_entry_t              data_a_s;
  wb_entry_t              data_b_s;
  wb_entry_t              head_s;
  logic                   push_a_s;
  logic                   push_b_s;
  logic                   pop_s;
  logic                   rdy_s;
  logic                   alu_acc_s;
  logic                   mem_acc_s;
  logic                   dual_s;
  logic                   rr_r;
  logic [AW:0]            cnt_s;
  logic [DEPTH-1:0]       vld_vec_s;
  logic [DEPTH-1:0][4:0]  rd_vec_s;
  logic                   hazard_s;
  logic                   wr_en_r;
  logic [4:0]             wr_addr_r;
  logic [31:0]            wr_dat_r;

  assign alu_req_s = '{vld: bus.alu_vld, rd: bus.alu_rd, dat: bus.alu_dat};
  assign mem_req_s = '{vld: bus.mem_vld, rd: bus.mem_rd, dat: bus.mem_dat};

  // Two free slots guarantee room for a dual push regardless of the pop.
  assign rdy_s     = (cnt_s <= (AW+1)'(DEPTH - 2));
  assign alu_acc_s = alu_req_s.vld & rdy_s & (alu_req_s.rd != 5'd0);
  assign mem_acc_s = mem_req_s.vld & rdy_s & (mem_req_s.rd != 5'd0);
  assign dual_s    = alu_acc_s & mem_acc_s;
  assign pop_s     = (cnt_s != (AW+1)'(0));

  // Order accepted requests into push slots a (older) and b (younger).
  always_comb begin
    push_a_s = 1'b0;
    push_b_s = 1'b0;
    data_a_s = mk_entry(mem_req_s);
    data_b_s = mk_entry(alu_req_s);
    if (dual_s) begin
      push_a_s = 1'b1;
      push_b_s = 1'b1;
      if (rr_r) begin
        data_a_s = mk_entry(alu_req_s);
        data_b_s = mk_entry(mem_req_s);
      end else begin
        data_a_s = mk_entry(mem_req_s);
        data_b_s = mk_entry(alu_req_s);
      end
    end else if (alu_acc_s) begin
      push_a_s = 1'b1;
      data_a_s = mk_entry(alu_req_s);
    end else if (mem_acc_s) begin
      push_a_s = 1'b1;
      data_a_s = mk_entry(mem_req_s);
    end else begin
      push_a_s = 1'b0;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_wb_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_a  (push_a_s),
    .data_a  (data_a_s),
    .push_b  (push_b_s),
    .data_b  (data_b_s),
    .pop     (pop_s),
    .head    (head_s),
    .cnt     (cnt_s),
    .vld_vec (vld_vec_s),
    .rd_vec  (rd_vec_s)
  );

  // Round-robin pointer and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_r      <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 5'd0;
      wr_dat_r  <= 32'd0;
    end else begin
      rr_r    <= rr_r ^ dual_s;
      wr_en_r <= pop_s;
      if (pop_s) begin
        wr_addr_r <= head_s.rd;
        wr_dat_r  <= head_s.dat;
      end
    end
  end

  // Hazard: any nonzero read index matching a queued rd or the write in flight.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hazard_s = hazard_s | (vld_vec_s[i] &
                 (((bus.rs1_ind != 5'd0) & (rd_vec_s[i] == bus.rs1_ind)) |
                  ((bus.rs2_ind != 5'd0) & (rd_vec_s[i] == bus.rs2_ind))));
    end
    hazard_s = hazard_s | (wr_en_r &
               (((bus.rs1_ind != 5'd0) & (wr_addr_r == bus.rs1_ind)) |
                ((bus.rs2_ind != 5'd0) & (wr_addr_r == bus.rs2_ind))));
  end

  assign bus.alu_rdy = rdy_s;
  assign bus.mem_rdy = rdy_s;
  assign bus.wr_en   = wr_en_r;
  assign bus.wr_addr = wr_addr_r;
  assign bus.wr_dat  = wr_dat_r;
  assign bus.hazard  = hazard_s;
  assign bus.cnt     = cnt_s;

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Directed plus randomized bench for regfile_wport_arb against a queue-based
// reference of the pending writes.
module tb_regfile_wport_arb;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  regfile_wport_arb_if #(.DEPTH(DEPTH)) bus ();

  regfile_wport_arb #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: pending writes as {rd, dat}, in the order they will be written.
  logic [36:0] pend [$];
  bit          m_rr;
  bit          m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_dat;
  logic [31:0] dut_rf [32];
  bit          last_alu_acc;
  bit          last_mem_acc;
  int          dut_wr_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit rs_hit(input logic [4:0] rs);
    bit h = 1'b0;
    if (rs != 5'd0) begin
      foreach (pend[i]) if (pend[i][36:32] == rs) h = 1'b1;
      if (m_wr_en && m_wr_addr == rs) h = 1'b1;
    end
    return h;
  endfunction

  function automatic void model_reset();
    pend.delete();
    m_rr      = 1'b0;
    m_wr_en   = 1'b0;
    m_wr_addr = 5'd0;
    m_wr_dat  = 32'd0;
  endfunction

  task automatic tick();
    bit rdy;
    bit a_ok;
    bit m_ok;
    #1;
    rdy = (pend.size() <= DEPTH - 2);
    chk("cnt", 64'(bus.cnt), 64'(pend.size()));
    chk("alu_rdy", 64'(bus.alu_rdy), 64'(rdy));
    chk("mem_rdy", 64'(bus.mem_rdy), 64'(rdy));
    chk("hazard", 64'(bus.hazard), 64'(rs_hit(bus.rs1_ind) | rs_hit(bus.rs2_ind)));
    chk("wr_en", 64'(bus.wr_en), 64'(m_wr_en));
    if (m_wr_en) begin
      chk("wr_addr", 64'(bus.wr_addr), 64'(m_wr_addr));
      chk("wr_dat", 64'(bus.wr_dat), 64'(m_wr_dat));
    end
    if (bus.wr_en === 1'b1) begin
      dut_rf[bus.wr_addr] = bus.wr_dat;
      dut_wr_count++;
    end
    last_alu_acc = bus.alu_vld && rdy;
    last_mem_acc = bus.mem_vld && rdy;
    a_ok = last_alu_acc && (bus.alu_rd != 5'd0);
    m_ok = last_mem_acc && (bus.mem_rd != 5'd0);
    @(posedge clk);
    if (pend.size() > 0) begin
      {m_wr_addr, m_wr_dat} = pend.pop_front();
      m_wr_en = 1'b1;
    end else begin
      m_wr_en = 1'b0;
    end
    if (a_ok && m_ok) begin
      if (m_rr) begin
        pend.push_back({bus.alu_rd, bus.alu_dat});
        pend.push_back({bus.mem_rd, bus.mem_dat});
      end else begin
        pend.push_back({bus.mem_rd, bus.mem_dat});
        pend.push_back({bus.alu_rd, bus.alu_dat});
      end
      m_rr = !m_rr;
    end else if (a_ok) begin
      pend.push_back({bus.alu_rd, bus.alu_dat});
    end else if (m_ok) begin
      pend.push_back({bus.mem_rd, bus.mem_dat});
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.alu_vld = 1'b0;
    bus.mem_vld = 1'b0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] dat);
    bus.alu_vld = 1'b1; bus.alu_rd = rd; bus.alu_dat = dat;
  endtask

  task automatic set_mem(input logic [4:0] rd, input logic [31:0] dat);
    bus.mem_vld = 1'b1; bus.mem_rd = rd; bus.mem_dat = dat;
  endtask

  initial begin
    int wr_before;
    foreach (dut_rf[i]) dut_rf[i] = 32'd0;
    dut_wr_count = 0;
    bus.alu_vld = 1'b0; bus.alu_rd = 5'd0; bus.alu_dat = 32'd0;
    bus.mem_vld = 1'b0; bus.mem_rd = 5'd0; bus.mem_dat = 32'd0;
    bus.rs1_ind = 5'd0; bus.rs2_ind = 5'd0;
    model_reset();

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cnt", 64'(bus.cnt), 64'd0);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_hazard", 64'(bus.hazard), 64'd0);
    chk("rst_rdy", 64'(bus.alu_rdy), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU write: wr_en two cycles later, hazard held meanwhile
    bus.rs1_ind = 5'd5;
    set_alu(5'd5, 32'h1234);
    tick();
    idle();
    tick();
    tick();
    chk("lat2_seen", 64'(dut_rf[5]), 64'h1234);
    tick();

    // Dual push after reset: mem first, then the next dual goes alu first
    bus.rs1_ind = 5'd3; bus.rs2_ind = 5'd4;
    set_mem(5'd3, 32'hA); set_alu(5'd4, 32'hB);
    tick();
    idle();
    repeat (3) tick();
    set_mem(5'd8, 32'hC); set_alu(5'd9, 32'hD);
    tick();
    idle();
    repeat (3) tick();

    // Write to x0 is accepted and dropped
    bus.rs1_ind = 5'd0; bus.rs2_ind = 5'd0;
    set_alu(5'd0, 32'hFFFF);
    tick();
    idle();
    repeat (2) tick();

    // Two writes to the same rd: younger value lands last
    bus.rs1_ind = 5'd7;
    set_alu(5'd7, 32'h1); tick();
    set_alu(5'd7, 32'h2); tick();
    idle();
    repeat (4) tick();
    chk("rf7_final", 64'(dut_rf[7]), 64'h2);

    // Both requesters held valid: backpressure and sustained drain
    set_alu(5'($urandom_range(1, 31)), $urandom);
    set_mem(5'($urandom_range(1, 31)), $urandom);
    repeat (4) begin
      tick();
      if (last_alu_acc) set_alu(5'($urandom_range(1, 31)), $urandom);
      if (last_mem_acc) set_mem(5'($urandom_range(1, 31)), $urandom);
    end
    wr_before = dut_wr_count;
    repeat (16) begin
      tick();
      if (last_alu_acc) set_alu(5'($urandom_range(1, 31)), $urandom);
      if (last_mem_acc) set_mem(5'($urandom_range(1, 31)), $urandom);
    end
    chk("throughput", 64'(dut_wr_count - wr_before), 64'd16);
    idle();
    repeat (4) tick();

    // Random traffic with narrow rd range to provoke hazards and x0 drops
    repeat (200) begin
      bus.alu_vld = 1'($urandom_range(0, 1));
      bus.alu_rd  = 5'($urandom_range(0, 7));
      bus.alu_dat = $urandom;
      bus.mem_vld = 1'($urandom_range(0, 1));
      bus.mem_rd  = 5'($urandom_range(0, 7));
      bus.mem_dat = $urandom;
      bus.rs1_ind = 5'($urandom_range(0, 7));
      bus.rs2_ind = 5'($urandom_range(0, 7));
      tick();
    end
    idle();
    repeat (4) tick();

    // Reset mid-operation with three writes pending
    set_alu(5'd12, 32'h55); set_mem(5'd13, 32'h66);
    for (int i = 0; i < 10 && pend.size() != 3; i++) tick();
    chk("pre_rst_cnt", 64'(bus.cnt), 64'd3);
    bus.rs1_ind = pend[0][36:32];
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 64'(bus.cnt), 64'd0);
    chk("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("mid_rst_hazard", 64'(bus.hazard), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wport_arb.md
REGFILE_WPORT_ARB -- requirements
Module: regfile_wport_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, pending-write queue depth; power of two, at least 4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port alu_vld, input, 1, ALU-result write request.
REQ-005 SHALL have port alu_rd, input, 5, ALU destination index.
REQ-006 SHALL have port alu_dat, input, 32, ALU write data.
REQ-007 SHALL have port alu_rdy, output, 1, ALU request accepted this cycle when high with alu_vld.
REQ-008 SHALL have ports mem_vld, mem_rd, mem_dat and mem_rdy, each matching its alu_* counterpart in direction, width and meaning, for load data.
REQ-009 SHALL have port wr_en, output, 1, register-file write enable.
REQ-010 SHALL have port wr_addr, output, 5, register-file write index.
REQ-011 SHALL have port wr_dat, output, 32, register-file write data.
REQ-012 SHALL have ports rs1_ind and rs2_ind, input, 5 each, decode read indices.
REQ-013 SHALL have port hazard, output, 1, decode must stall because a read index has a write still pending.
REQ-014 SHALL have port cnt, output, log2(DEPTH)+1, current queue occupancy.

Function
REQ-015 SHALL hold accepted writes in a DEPTH-entry in-order FIFO of {rd, dat}.
REQ-016 SHALL drive alu_rdy = mem_rdy = (cnt <= DEPTH-2), combinationally from registered cnt, with no dependence on the vld inputs.
REQ-017 SHALL treat a request as accepted only when vld and rdy are both high in the same cycle.
REQ-018 SHALL accept but discard any request with rd = 0; it is not pushed, not written and never causes hazard.
REQ-019 SHALL push a single accepted request in that cycle.
REQ-020 SHALL push two simultaneous accepted requests in one cycle, ordered by a 1-bit round-robin pointer rr (0 = mem first, 1 = alu first); rr toggles after every dual push.
REQ-021 SHALL pop the FIFO head when cnt > 0 and register it onto wr_en/wr_addr/wr_dat next cycle; otherwise wr_en = 0 next cycle.
REQ-022 SHALL have a minimum latency of 2 cycles from acceptance to wr_en, for the single entry in an empty FIFO.
REQ-023 SHALL pop, push and update cnt in the same cycle, with next cnt = cnt + pushes - pop and no overflow or underflow.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL drive hazard high when rs1_ind or rs2_ind is nonzero and equals the rd of any valid FIFO entry, or equals wr_addr while wr_en is high.
REQ-026 SHALL compute hazard combinationally from registered state only.
REQ-027 SHALL write two pending entries to the same rd in FIFO order, so the younger value prevails.

Reset
REQ-028 SHALL, on rst_n low, immediately clear cnt, the pointers, rr, wr_en, wr_addr and wr_dat to 0 and invalidate all entries.
REQ-029 SHALL discard pending writes on reset mid-operation; hazard and wr_en read 0 during reset.
REQ-030 SHALL accept requests from the first rising edge after rst_n deasserts.

Structure
REQ-031 SHALL take the {rd, dat} entry typedef and the default DEPTH from the shared types package, alongside the writeback-interface types.
REQ-032 SHALL implement the queue as sub-module wb_fifo with dual push and single pop; hazard compare and arbitration stay in the top level.

Verification
REQ-033 Single ALU write {rd=5, dat=0x1234} into an empty FIFO -> wr_en=1, wr_addr=5, wr_dat=0x1234 exactly 2 cycles later; hazard=1 for rs1_ind=5 through that cycle.
REQ-034 Simultaneous mem {rd=3, 0xA} and alu {rd=4, 0xB} after reset (rr=0) -> writes rd 3 then rd 4 on consecutive cycles; the next dual push writes alu first.
REQ-035 Both requesters held valid continuously -> rdy drops when cnt reaches 3 (DEPTH=4); no entry is lost or duplicated; 1 write per cycle is sustained.
REQ-036 alu {rd=0, 0xFFFF} -> alu_rdy=1, cnt unchanged, no wr_en, hazard=0 for rs1_ind=0.
REQ-037 Two writes to rd=7 (0x1 then 0x2) -> final register value 0x2; hazard stays high until the second write is issued.
REQ-038 rst_n pulsed low with cnt=3 -> wr_en, cnt and hazard go to 0 immediately; no stale writes follow release.
